// File: rtl/lca_multi_sequencer.sv
// lca_multi_sequencer: expands LM/SM into one LW/SW micro-op per cycle,
// freezing PC/fetch and steering decode onto the generated micro-op.
module lca_multi_sequencer #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned NREG       = 8,
    parameter int unsigned REG_AW     = 3,
    parameter logic [3:0]  OP_LM      = 4'b0110,
    parameter logic [3:0]  OP_SM      = 4'b0111,
    parameter logic [3:0]  OP_LW      = 4'b0100,
    parameter logic [3:0]  OP_SW      = 4'b0101,
    parameter bit          DESCENDING = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_ir,
    input  logic              stall_in,
    input  logic              flush,
    output logic              mop_valid,
    output logic [DATA_W-1:0] mop_ir,
    output logic              mop_first,
    output logic              mop_last,
    output logic              ir_load_mux,
    output logic              pc_write,
    output logic              busy
);

    localparam int unsigned OFF_W = DATA_W - 4 - 2 * REG_AW;
    localparam int unsigned CNT_W = $clog2(NREG) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_t;

    state_t            state;
    logic [NREG-1:0]   pend;       // registers still to be emitted after the current micro-op
    logic [REG_AW-1:0] base_r;
    logic              is_load_r;
    logic [CNT_W-1:0]  off_r;      // offset of the micro-op currently presented

    logic [3:0]        in_op;
    logic [NREG-1:0]   in_mask;
    logic [REG_AW-1:0] in_base;
    logic              is_mult_c;
    logic              accept_c;
    logic [NREG-1:0]   src_mask;
    logic [REG_AW-1:0] sel_idx;
    logic [NREG-1:0]   sel_bit;
    logic [NREG-1:0]   pend_after;
    logic [CNT_W-1:0]  in_cnt;
    logic [CNT_W-1:0]  first_off;
    logic [CNT_W-1:0]  next_off;
    logic              emit_load;
    logic [REG_AW-1:0] emit_base;
    logic [CNT_W-1:0]  emit_off;
    logic [DATA_W-1:0] emit_ir;
    logic              unused_ir;

    // Instruction field extraction
    assign in_op     = in_ir[DATA_W-1 -: 4];
    assign in_mask   = in_ir[NREG-1:0];
    assign in_base   = in_ir[DATA_W-5 -: REG_AW];
    assign unused_ir = ^in_ir;

    assign is_mult_c = in_valid && ((in_op == OP_LM) || (in_op == OP_SM));
    assign accept_c  = (state == IDLE) && is_mult_c && (in_mask != '0) && !stall_in && !flush;

    // In IDLE the next micro-op comes from the incoming mask, in SEQ from the pending one
    assign src_mask = (state == IDLE) ? in_mask : pend;

    // Priority select of the next register in transfer order
    always_comb begin
        sel_idx = '0;
        if (DESCENDING) begin
            for (int i = 0; i < int'(NREG); i++) begin
                if (src_mask[i]) sel_idx = REG_AW'(i);
            end
        end else begin
            for (int i = int'(NREG) - 1; i >= 0; i--) begin
                if (src_mask[i]) sel_idx = REG_AW'(i);
            end
        end
    end

    assign sel_bit    = NREG'(1) << sel_idx;
    assign pend_after = src_mask & ~sel_bit;

    // Register count of the incoming mask, used as the starting offset when descending
    always_comb begin
        in_cnt = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            in_cnt = in_cnt + CNT_W'(in_mask[i]);
        end
    end

    // Offsets follow register rank so memory layout is independent of transfer order
    assign first_off = DESCENDING ? (in_cnt - CNT_W'(1)) : '0;
    assign next_off  = DESCENDING ? (off_r - CNT_W'(1)) : (off_r + CNT_W'(1));

    assign emit_load = (state == IDLE) ? (in_op == OP_LM) : is_load_r;
    assign emit_base = (state == IDLE) ? in_base : base_r;
    assign emit_off  = (state == IDLE) ? first_off : next_off;
    assign emit_ir   = {(emit_load ? OP_LW : OP_SW), sel_idx, emit_base, OFF_W'(emit_off)};

    // Sequencer state and registered micro-op outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pend      <= '0;
            base_r    <= '0;
            is_load_r <= 1'b0;
            off_r     <= '0;
            mop_valid <= 1'b0;
            mop_ir    <= '0;
            mop_first <= 1'b0;
            mop_last  <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            pend      <= '0;
            mop_valid <= 1'b0;
            mop_ir    <= '0;
            mop_first <= 1'b0;
            mop_last  <= 1'b0;
        end else if (!stall_in) begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        state     <= SEQ;
                        base_r    <= in_base;
                        is_load_r <= (in_op == OP_LM);
                        off_r     <= first_off;
                        pend      <= pend_after;
                        mop_valid <= 1'b1;
                        mop_ir    <= emit_ir;
                        mop_first <= 1'b1;
                        mop_last  <= (pend_after == '0);
                    end
                end
                SEQ: begin
                    if (pend == '0) begin
                        state     <= IDLE;
                        mop_valid <= 1'b0;
                        mop_ir    <= '0;
                        mop_first <= 1'b0;
                        mop_last  <= 1'b0;
                    end else begin
                        off_r     <= next_off;
                        pend      <= pend_after;
                        mop_valid <= 1'b1;
                        mop_ir    <= emit_ir;
                        mop_first <= 1'b0;
                        mop_last  <= (pend_after == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status and pipeline control; PC is released while the last micro-op is presented
    assign busy        = (state == SEQ);
    assign ir_load_mux = busy;
    assign pc_write    = !(accept_c || (busy && (pend != '0)));

endmodule

// File: tb/tb_lca_multi_sequencer.sv
// Bench for lca_multi_sequencer: ascending, descending and 16-register instances
// checked against a rank-based model of the expected micro-op stream.
module tb_lca_multi_sequencer;

    localparam logic [3:0] LM = 4'b0110;
    localparam logic [3:0] SM = 4'b0111;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        stall_in;
    logic        flush;
    logic [15:0] n_ir;
    logic [23:0] w_ir;

    logic        a_valid, a_first, a_last, a_mux, a_pc, a_busy;
    logic        d_valid, d_first, d_last, d_mux, d_pc, d_busy;
    logic        w_valid, w_first, w_last, w_mux, w_pc, w_busy;
    logic [15:0] a_ir, d_ir;
    logic [23:0] w_mop;
    logic [5:0]  a_flags, d_flags, w_flags;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lca_multi_sequencer #(.DESCENDING(1'b0)) u_asc (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ir(n_ir),
        .stall_in(stall_in), .flush(flush), .mop_valid(a_valid), .mop_ir(a_ir),
        .mop_first(a_first), .mop_last(a_last), .ir_load_mux(a_mux),
        .pc_write(a_pc), .busy(a_busy));

    lca_multi_sequencer #(.DESCENDING(1'b1)) u_desc (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ir(n_ir),
        .stall_in(stall_in), .flush(flush), .mop_valid(d_valid), .mop_ir(d_ir),
        .mop_first(d_first), .mop_last(d_last), .ir_load_mux(d_mux),
        .pc_write(d_pc), .busy(d_busy));

    lca_multi_sequencer #(.DATA_W(24), .NREG(16), .REG_AW(4)) u_wide (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ir(w_ir),
        .stall_in(stall_in), .flush(flush), .mop_valid(w_valid), .mop_ir(w_mop),
        .mop_first(w_first), .mop_last(w_last), .ir_load_mux(w_mux),
        .pc_write(w_pc), .busy(w_busy));

    assign a_flags = {a_valid, a_first, a_last, a_busy, a_mux, a_pc};
    assign d_flags = {d_valid, d_first, d_last, d_busy, d_mux, d_pc};
    assign w_flags = {w_valid, w_first, w_last, w_busy, w_mux, w_pc};

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] get_op(input bit wide, input logic [23:0] ir);
        return wide ? ir[23:20] : ir[15:12];
    endfunction

    function automatic int get_n(input bit wide, input logic [23:0] ir);
        int n;
        n = 0;
        for (int i = 0; i < (wide ? 16 : 8); i++) if (ir[i]) n++;
        return n;
    endfunction

    // Register of rank j sits at offset j; descending order walks ranks backwards
    function automatic logic [23:0] exp_mop(input bit wide, input bit desc, input logic [23:0] ir, input int k);
        int regs[16];
        int n;
        int j;
        logic [3:0] op;
        n = 0;
        for (int i = 0; i < (wide ? 16 : 8); i++) begin
            if (ir[i]) begin
                regs[n] = i;
                n++;
            end
        end
        j = desc ? (n - 1 - k) : k;
        op = (get_op(wide, ir) == LM) ? 4'b0100 : 4'b0101;
        if (wide) return {op, 4'(regs[j]), ir[19:16], 12'(j)};
        return 24'({op, 3'(regs[j]), ir[11:9], 6'(j)});
    endfunction

    task automatic check_cycle(input string tag, input bit wide, input logic [23:0] ir,
                               input bit ev, input bit ef, input bit el, input bit eb,
                               input bit ep, input int k);
        logic [5:0] ex;
        ex = {ev, ef, el, eb, eb, ep};
        if (!wide) begin
            chk({tag, " asc flags"}, 24'(a_flags), 24'(ex));
            chk({tag, " desc flags"}, 24'(d_flags), 24'(ex));
            if (ev) begin
                chk({tag, " asc mop_ir"}, 24'(a_ir), exp_mop(1'b0, 1'b0, ir, k));
                chk({tag, " desc mop_ir"}, 24'(d_ir), exp_mop(1'b0, 1'b1, ir, k));
            end
        end else begin
            chk({tag, " wide flags"}, 24'(w_flags), 24'(ex));
            if (ev) chk({tag, " wide mop_ir"}, w_mop, exp_mop(1'b1, 1'b0, ir, k));
        end
    endtask

    // One instruction: present it, then follow the micro-op stream cycle by cycle
    task automatic run_seq(input string tag, input bit wide, input logic [23:0] ir,
                           input int stall_k, input int stall_n, input int abort_k,
                           input bit abort_rst);
        int n;
        int k;
        int sd;
        bit mult;
        @(posedge clk); #1;
        in_valid = 1'b1;
        if (wide) begin w_ir = ir; n_ir = '0; end
        else begin n_ir = ir[15:0]; w_ir = '0; end
        n = get_n(wide, ir);
        mult = (get_op(wide, ir) == LM) || (get_op(wide, ir) == SM);
        @(negedge clk);
        if (!mult || n == 0) begin
            check_cycle({tag, " pass"}, wide, ir, 0, 0, 0, 0, 1, 0);
            @(posedge clk); #1;
            in_valid = 1'b0; n_ir = '0; w_ir = '0;
            @(negedge clk);
            check_cycle({tag, " pass next"}, wide, ir, 0, 0, 0, 0, 1, 0);
            return;
        end
        check_cycle({tag, " accept"}, wide, ir, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        in_valid = 1'b0; n_ir = '0; w_ir = '0;
        k = 0;
        sd = 0;
        while (k < n) begin
            @(negedge clk);
            check_cycle($sformatf("%s k%0d", tag, k), wide, ir, 1, k == 0, k == n - 1, 1, k == n - 1, k);
            if (k == abort_k) begin
                stall_in = 1'b0;
                if (abort_rst) reset = 1'b1; else flush = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0; flush = 1'b0;
                @(negedge clk);
                check_cycle({tag, abort_rst ? " after reset" : " after flush"}, wide, ir, 0, 0, 0, 0, 1, 0);
                if (abort_rst) chk({tag, " reset mop_ir"}, wide ? w_mop : 24'(a_ir), 24'h0);
                return;
            end
            if (k == stall_k && sd < stall_n) begin
                stall_in = 1'b1;
                sd++;
            end else begin
                stall_in = 1'b0;
                k++;
            end
        end
        @(negedge clk);
        check_cycle({tag, " done"}, wide, ir, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        logic [23:0] ir;
        logic [3:0]  op;
        bit          wide;
        int          n;
        int          ak;
        reset = 1'b1; in_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
        n_ir = '0; w_ir = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_cycle("reset", 1'b0, 24'h0, 0, 0, 0, 0, 1, 0);
        check_cycle("reset", 1'b1, 24'h0, 0, 0, 0, 0, 1, 0);
        chk("reset asc mop_ir", 24'(a_ir), 24'h0);
        chk("reset wide mop_ir", w_mop, 24'h0);

        run_seq("lm_r1_25", 1'b0, 24'h6225, -1, 0, -1, 1'b0);
        run_seq("sm_ff_stall", 1'b0, 24'h76FF, 3, 2, -1, 1'b0);
        run_seq("lm_mask0", 1'b0, 24'h6200, -1, 0, -1, 1'b0);
        run_seq("lm_single_r7", 1'b0, 24'h6A80, -1, 0, -1, 1'b0);
        run_seq("lm4_flush", 1'b0, 24'h625A, -1, 0, 1, 1'b0);
        run_seq("lm4_reset", 1'b0, 24'h625A, -1, 0, 1, 1'b1);
        run_seq("wide_8001", 1'b1, 24'h628001, -1, 0, -1, 1'b0);
        run_seq("wide_sm_stall", 1'b1, 24'h7F1234, 0, 1, -1, 1'b0);

        // Flush or stall in the presentation cycle blocks acceptance
        for (int v = 0; v < 2; v++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; n_ir = 16'h620F;
            if (v == 0) flush = 1'b1; else stall_in = 1'b1;
            @(negedge clk);
            check_cycle($sformatf("blocked%0d", v), 1'b0, 24'h620F, 0, 0, 0, 0, 1, 0);
            @(posedge clk); #1;
            in_valid = 1'b0; n_ir = '0; flush = 1'b0; stall_in = 1'b0;
            @(negedge clk);
            check_cycle($sformatf("blocked%0d next", v), 1'b0, 24'h620F, 0, 0, 0, 0, 1, 0);
        end

        // Randomized instructions, stalls and aborts
        for (int t = 0; t < 30; t++) begin
            wide = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0, 1: op = LM;
                2, 3: op = SM;
                default: op = 4'($urandom_range(0, 15));
            endcase
            if (wide) ir = {op, 4'($urandom_range(0, 15)), 16'($urandom)};
            else ir = {8'h0, op, 3'($urandom_range(0, 7)), 1'($urandom), 8'($urandom)};
            if ($urandom_range(0, 7) == 0) ir[15:0] = wide ? 16'h0 : {ir[15:8], 8'h0};
            n = get_n(wide, ir);
            ak = ($urandom_range(0, 4) == 0) ? $urandom_range(0, (n > 0) ? n - 1 : 0) : -1;
            run_seq($sformatf("rnd%0d", t), wide, ir, $urandom_range(0, 8), $urandom_range(0, 3),
                    ak, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
